stream_demux: RTL and testbench

- Inverse of the 2:1 `Multiplexor`: routes one input stream to one of two output streams, chosen per transfer by `sel`.
- Each output has a one-entry registered slot with valid/ready handshaking, so the two downstream consumers stall independently.
- Sits between a single producer (e.g. a decode stage) and two consumers; pairs with `Multiplexor` to split and later rejoin a datapath.

---
 rtl/stream_demux_pkg.sv | 11 +
 rtl/stream_demux_if.sv | 45 ++++
 rtl/stream_demux_slot.sv | 57 +++++
 rtl/stream_demux.sv | 69 ++++++
 tb/tb_stream_demux.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants for the 1:2 stream demultiplexer.
// Optional per-output transfer counters are enabled by STREAM_DEMUX_COUNT_EN.
package stream_demux_pkg;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

    localparam int unsigned DATA_WIDTH_DEFAULT  = 32;
    localparam int unsigned COUNT_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/stream_demux_if.sv
// Handshake bundle between the producer, the demux and its two consumers.
// Counter signals exist only when STREAM_DEMUX_COUNT_EN is defined.
interface stream_demux_if #(
    parameter int unsigned DATA_WIDTH = stream_demux_pkg::DATA_WIDTH_DEFAULT
`ifdef STREAM_DEMUX_COUNT_EN
    , parameter int unsigned COUNT_WIDTH = stream_demux_pkg::COUNT_WIDTH_DEFAULT
`endif
) ();

    logic [DATA_WIDTH-1:0]  in_data;
    logic                   in_valid;
    logic                   sel;
    logic                   in_ready;

    logic [DATA_WIDTH-1:0]  out0_data;
    logic                   out0_valid;
    logic                   out0_ready;
    logic [DATA_WIDTH-1:0]  out1_data;
    logic                   out1_valid;
    logic                   out1_ready;

`ifdef STREAM_DEMUX_COUNT_EN
    logic [COUNT_WIDTH-1:0] out0_count;
    logic [COUNT_WIDTH-1:0] out1_count;
`endif

    // Demux side.
    modport slave (
        input  in_data, in_valid, sel, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid
`ifdef STREAM_DEMUX_COUNT_EN
        , output out0_count, out1_count
`endif
    );

    // Producer and consumer side.
    modport master (
        output in_data, in_valid, sel, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid
`ifdef STREAM_DEMUX_COUNT_EN
        , input out0_count, out1_count
`endif
    );

endinterface

// File: rtl/stream_demux_slot.sv
// One-entry registered output slot with valid/ready handshake.
// Carries a wrapping handshake counter when STREAM_DEMUX_COUNT_EN is defined.
module stream_demux_slot #(
    parameter int unsigned DATA_WIDTH = 32
`ifdef STREAM_DEMUX_COUNT_EN
    , parameter int unsigned COUNT_WIDTH = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [DATA_WIDTH-1:0]  load_data,
    input  logic                   ready,
    output logic                   valid,
    output logic [DATA_WIDTH-1:0]  data
`ifdef STREAM_DEMUX_COUNT_EN
    , output logic [COUNT_WIDTH-1:0] count
`endif
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  drain;

    assign drain = valid_q && ready;

    // Load wins over drain so a same-cycle refill keeps the slot full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

`ifdef STREAM_DEMUX_COUNT_EN
    logic [COUNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (drain) begin
            count_q <= count_q + COUNT_WIDTH'(1);
        end
    end

    assign count = count_q;
`endif

endmodule

// File: rtl/stream_demux.sv
// Routes one valid/ready stream to one of two registered output slots chosen by sel.
// Define STREAM_DEMUX_COUNT_EN to add per-output handshake counters.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
`ifdef STREAM_DEMUX_COUNT_EN
    , parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEFAULT
`endif
) (
    input logic           clk,
    input logic           rst_n,
    stream_demux_if.slave bus
);

    logic slot0_free;
    logic slot1_free;
    logic in_ready;
    logic load0;
    logic load1;

    // Only the selected slot gates acceptance; the other may stall freely.
    always_comb begin
        slot0_free = !bus.out0_valid || bus.out0_ready;
        slot1_free = !bus.out1_valid || bus.out1_ready;
        in_ready   = (bus.sel == SEL_OUT1) ? slot1_free : slot0_free;
        load0      = bus.in_valid && in_ready && (bus.sel == SEL_OUT0);
        load1      = bus.in_valid && in_ready && (bus.sel == SEL_OUT1);
    end

    assign bus.in_ready = in_ready;

    stream_demux_slot #(
        .DATA_WIDTH (DATA_WIDTH)
`ifdef STREAM_DEMUX_COUNT_EN
        , .COUNT_WIDTH(COUNT_WIDTH)
`endif
    ) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load0),
        .load_data (bus.in_data),
        .ready     (bus.out0_ready),
        .valid     (bus.out0_valid),
        .data      (bus.out0_data)
`ifdef STREAM_DEMUX_COUNT_EN
        , .count   (bus.out0_count)
`endif
    );

    stream_demux_slot #(
        .DATA_WIDTH (DATA_WIDTH)
`ifdef STREAM_DEMUX_COUNT_EN
        , .COUNT_WIDTH(COUNT_WIDTH)
`endif
    ) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load1),
        .load_data (bus.in_data),
        .ready     (bus.out1_ready),
        .valid     (bus.out1_valid),
        .data      (bus.out1_data)
`ifdef STREAM_DEMUX_COUNT_EN
        , .count   (bus.out1_count)
`endif
    );

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: per-output FIFO reference model, randomized traffic.
// Counter checks are compiled in when STREAM_DEMUX_COUNT_EN is defined.
module tb_stream_demux;

    localparam int DW = 32;
`ifdef STREAM_DEMUX_COUNT_EN
    localparam int CW = 4;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    stream_demux_if #(
        .DATA_WIDTH (DW)
`ifdef STREAM_DEMUX_COUNT_EN
        , .COUNT_WIDTH(CW)
`endif
    ) bus ();

    stream_demux #(
        .DATA_WIDTH (DW)
`ifdef STREAM_DEMUX_COUNT_EN
        , .COUNT_WIDTH(CW)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int hs0   = 0;
    int hs1   = 0;
    bit rand_rdy = 1'b0;
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    logic [DW-1:0] exp0, exp1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && bus.in_valid)
            assert (!$isunknown(bus.sel)) else $error("FAIL sel_known: sel is X while in_valid");
    end

    // Monitor: each output is an independent FIFO; a slot is full iff its queue is non-empty.
    always @(negedge clk) begin
        if (rst_n) begin
            check("out0_valid", 64'(bus.out0_valid), 64'(exp_q0.size() != 0));
            check("out1_valid", 64'(bus.out1_valid), 64'(exp_q1.size() != 0));
            if (bus.in_valid)
                check("in_ready", 64'(bus.in_ready),
                      bus.sel ? 64'(exp_q1.size() == 0 || bus.out1_ready)
                              : 64'(exp_q0.size() == 0 || bus.out0_ready));
`ifdef STREAM_DEMUX_COUNT_EN
            check("out0_count", 64'(bus.out0_count), 64'(hs0 % (1 << CW)));
            check("out1_count", 64'(bus.out1_count), 64'(hs1 % (1 << CW)));
`endif
            if (bus.out0_valid && bus.out0_ready) begin
                if (exp_q0.size() == 0) begin
                    check("out0_unexpected", 64'(1), 64'(0));
                end else begin
                    exp0 = exp_q0.pop_front();
                    check("out0_data", 64'(bus.out0_data), 64'(exp0));
                end
                hs0++;
            end
            if (bus.out1_valid && bus.out1_ready) begin
                if (exp_q1.size() == 0) begin
                    check("out1_unexpected", 64'(1), 64'(0));
                end else begin
                    exp1 = exp_q1.pop_front();
                    check("out1_data", 64'(bus.out1_data), 64'(exp1));
                end
                hs1++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            bus.out0_ready = ($urandom_range(0, 3) != 0);
            bus.out1_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Holds the payload until accepted, pushing the expectation at acceptance.
    task automatic send(input logic s, input logic [DW-1:0] d);
        int  t;
        bit  acc;
        bus.in_valid = 1'b1;
        bus.sel      = s;
        bus.in_data  = d;
        t = 0;
        while (1) begin
            @(negedge clk);
            #1;
            acc = bus.in_ready;
            if (acc) begin
                if (s) exp_q1.push_back(d);
                else   exp_q0.push_back(d);
            end
            tick();
            if (acc) break;
            t++;
            if (t > 200) begin
                check("send_timeout", 64'(0), 64'(1));
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out0_valid", 64'(bus.out0_valid), 64'(0));
        check("rst_out1_valid", 64'(bus.out1_valid), 64'(0));
        check("rst_out0_data", 64'(bus.out0_data), 64'(0));
        check("rst_out1_data", 64'(bus.out1_data), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
`ifdef STREAM_DEMUX_COUNT_EN
        check("rst_out0_count", 64'(bus.out0_count), 64'(0));
        check("rst_out1_count", 64'(bus.out1_count), 64'(0));
`endif
        exp_q0.delete();
        exp_q1.delete();
        hs0 = 0;
        hs1 = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_out0_valid", 64'(bus.out0_valid), 64'(0));
        check("post_rst_out1_valid", 64'(bus.out1_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.sel        = 1'b0;
        bus.in_data    = '0;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        do_reset();

        // Basic routing and one-cycle latency.
        send(1'b0, DW'(100));
        check("lat_out0_valid", 64'(bus.out0_valid), 64'(1));
        check("lat_out0_data", 64'(bus.out0_data), 64'(100));
        check("lat_out1_valid", 64'(bus.out1_valid), 64'(0));
        send(1'b1, DW'(200));
        check("lat_out1_data", 64'(bus.out1_data), 64'(200));
        check("lat_out0_drained", 64'(bus.out0_valid), 64'(0));
        tick();

        // Back-to-back alternating destinations, no bubble.
        send(1'b0, DW'(1));
        check("b2b_out0_data", 64'(bus.out0_data), 64'(1));
        send(1'b1, DW'(12));
        check("b2b_out0_one_cycle", 64'(bus.out0_valid), 64'(0));
        check("b2b_out1_data", 64'(bus.out1_data), 64'(12));
        tick();
        check("b2b_out1_one_cycle", 64'(bus.out1_valid), 64'(0));

        // Backpressure on out0 only.
        bus.out0_ready = 1'b0;
        send(1'b0, DW'(7));
        send(1'b1, DW'(9));
        check("bp_out0_hold", 64'(bus.out0_data), 64'(7));
        check("bp_out1_data", 64'(bus.out1_data), 64'(9));
        bus.in_valid = 1'b1;
        bus.sel      = 1'b0;
        bus.in_data  = DW'(8);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
            tick();
        end
        check("bp_out0_stable", 64'(bus.out0_data), 64'(7));
        bus.out0_ready = 1'b1;
        send(1'b0, DW'(8));
        check("bp_out0_refill", 64'(bus.out0_data), 64'(8));
        tick();
        tick();

        // Streaming into out1 with load and drain in the same cycle.
        for (int i = 1; i <= 3; i++) begin
            send(1'b1, DW'(i));
            check("stream_out1_valid", 64'(bus.out1_valid), 64'(1));
            check("stream_out1_data", 64'(bus.out1_data), 64'(i));
        end
        tick();

`ifdef STREAM_DEMUX_COUNT_EN
        do_reset();
        for (int i = 0; i < 17; i++) send(1'b0, DW'(i + 50));
        tick();
        check("cnt_out0_wrapped", 64'(bus.out0_count), 64'(1));
        check("cnt_out1_zero", 64'(bus.out1_count), 64'(0));
        do_reset();
`endif

        // Randomized traffic with random backpressure and a reset in the middle.
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            if ($urandom_range(0, 3) == 0) tick();
            else send(1'($urandom_range(0, 1)), DW'($urandom));
        end

        rand_rdy       = 1'b0;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        repeat (4) tick();
        check("drain_q0_empty", 64'(exp_q0.size()), 64'(0));
        check("drain_q1_empty", 64'(exp_q1.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
